keccak_squeeze_serializer: RTL and testbench

- Output-side counterpart to the combinational state-array datapath.
- Accepts one complete 5x5x64 Keccak state array in a single cycle through a valid/ready handshake, and stores it.
- Streams the first N lanes out as 64-bit words, one per handshake, in FIPS 202 lane order.
- Sits between the permutation core and the digest/XOF output port during the squeeze phase.

---
 rtl/keccak_pkg.sv | 26 ++
 rtl/keccak_lane_select.sv | 47 ++++
 rtl/keccak_squeeze_serializer.sv | 122 ++++++++++++
 tb/tb_keccak_squeeze_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// ---------------------------------------------------------------------------
// keccak_pkg
// Shared Keccak-f[1600] geometry and types.
//   ROW_SIZE / COL_SIZE : 5x5 lane grid, indexed [x][y]
//   LANE_SIZE           : lane width in bits (64)
//   NUM_LANES           : lanes per state (25)
//   LANE_IDX_W          : width of a FIPS 202 lane index i = x + 5*y
//   state_array_t       : full state, indexed [x][y][z]
//   squeeze_state_e     : control states of the squeeze serializer
// ---------------------------------------------------------------------------
package keccak_pkg;

    localparam int ROW_SIZE   = 5;
    localparam int COL_SIZE   = 5;
    localparam int LANE_SIZE  = 64;
    localparam int NUM_LANES  = ROW_SIZE * COL_SIZE;
    localparam int LANE_IDX_W = 5;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_t;

    typedef enum logic {
        SQ_IDLE   = 1'b0,
        SQ_STREAM = 1'b1
    } squeeze_state_e;

endpackage

// File: rtl/keccak_lane_select.sv
// ---------------------------------------------------------------------------
// keccak_lane_select
// Combinational 25:1 lane mux: lane i = state[i mod 5][i / 5].
//   i_state : full Keccak state, indexed [x][y][z]
//   i_idx   : FIPS 202 lane index (0..24); out-of-range indices give zero
//   o_lane  : selected 64-bit lane
// ---------------------------------------------------------------------------
module keccak_lane_select
    import keccak_pkg::*;
(
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] i_state,
    input  logic [LANE_IDX_W-1:0]                            i_idx,
    output logic [LANE_SIZE-1:0]                             o_lane
);

    logic [2:0] w_x;
    logic [2:0] w_y;
    logic       w_in_range;

    // Range bands replace a divider: y is the band, x the offset inside it.
    always_comb begin
        w_x        = 3'd0;
        w_y        = 3'd0;
        w_in_range = 1'b1;
        if (i_idx < 5'd5) begin
            w_y = 3'd0;
            w_x = i_idx[2:0];
        end else if (i_idx < 5'd10) begin
            w_y = 3'd1;
            w_x = 3'(i_idx - 5'd5);
        end else if (i_idx < 5'd15) begin
            w_y = 3'd2;
            w_x = 3'(i_idx - 5'd10);
        end else if (i_idx < 5'd20) begin
            w_y = 3'd3;
            w_x = 3'(i_idx - 5'd15);
        end else if (i_idx < 5'd25) begin
            w_y = 3'd4;
            w_x = 3'(i_idx - 5'd20);
        end else begin
            w_in_range = 1'b0;
        end
    end

    assign o_lane = w_in_range ? i_state[w_x][w_y] : '0;

endmodule

// File: rtl/keccak_squeeze_serializer.sv
// ---------------------------------------------------------------------------
// keccak_squeeze_serializer
// Captures one full Keccak state per handshake and streams its first n lanes
// (n = min(num_lanes_i, 25)) as 64-bit words in FIPS 202 lane order.
//   clk, rst        : clock, synchronous active-high reset
//   state_valid_i   : state_array_i / num_lanes_i valid
//   state_ready_o   : block can accept a state (IDLE)
//   state_array_i   : state, indexed [x][y][z]
//   num_lanes_i     : lanes to emit for this state (26..31 saturate to 25)
//   lane_valid_o    : lane outputs valid
//   lane_ready_i    : downstream accepts the lane
//   lane_data_o     : current lane
//   lane_idx_o      : lane index i = x + 5*y
//   lane_last_o     : current lane is the final one of this state
//   done_o          : one-cycle pulse after last transfer or an empty load
// ---------------------------------------------------------------------------
module keccak_squeeze_serializer
    import keccak_pkg::*;
#(
    parameter int MAX_LANES = NUM_LANES,
    parameter int LANE_W    = LANE_SIZE
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            state_valid_i,
    output logic                                            state_ready_o,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
    input  logic [LANE_IDX_W-1:0]                           num_lanes_i,
    output logic                                            lane_valid_o,
    input  logic                                            lane_ready_i,
    output logic [LANE_W-1:0]                               lane_data_o,
    output logic [LANE_IDX_W-1:0]                           lane_idx_o,
    output logic                                            lane_last_o,
    output logic                                            done_o
);

    squeeze_state_e          r_fsm;
    squeeze_state_e          w_fsm_next;
    state_array_t            r_state;
    logic [LANE_IDX_W-1:0]   r_cnt;
    logic [LANE_IDX_W-1:0]   w_cnt_next;
    logic [LANE_IDX_W-1:0]   r_n;
    logic [LANE_IDX_W-1:0]   w_n_next;
    logic                    r_done;
    logic                    w_done_next;
    logic                    w_load;
    logic                    w_streaming;
    logic                    w_last;
    logic [LANE_IDX_W-1:0]   w_n_sat;
    logic [LANE_SIZE-1:0]    w_lane;

    keccak_lane_select u_lane_select (
        .i_state (r_state),
        .i_idx   (r_cnt),
        .o_lane  (w_lane)
    );

    assign w_n_sat     = (num_lanes_i > LANE_IDX_W'(MAX_LANES)) ? LANE_IDX_W'(MAX_LANES)
                                                                : num_lanes_i;
    assign w_streaming = (r_fsm == SQ_STREAM);
    // r_n >= 1 whenever streaming, so n-1 never wraps here.
    assign w_last      = w_streaming && (r_cnt == (r_n - 5'd1));

    always_comb begin
        w_fsm_next  = r_fsm;
        w_cnt_next  = r_cnt;
        w_n_next    = r_n;
        w_done_next = 1'b0;
        w_load      = 1'b0;
        case (r_fsm)
            SQ_IDLE: begin
                if (state_valid_i) begin
                    w_load     = 1'b1;
                    w_n_next   = w_n_sat;
                    w_cnt_next = '0;
                    if (w_n_sat == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_fsm_next = SQ_STREAM;
                    end
                end
            end
            SQ_STREAM: begin
                if (lane_ready_i) begin
                    if (w_last) begin
                        w_fsm_next  = SQ_IDLE;
                        w_done_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
            end
            default: w_fsm_next = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= SQ_IDLE;
            r_state <= '0;
            r_cnt   <= '0;
            r_n     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_next;
            r_cnt  <= w_cnt_next;
            r_n    <= w_n_next;
            r_done <= w_done_next;
            if (w_load) begin
                r_state <= state_array_i;
            end
        end
    end

    assign state_ready_o = ~w_streaming;
    assign lane_valid_o  = w_streaming;
    assign lane_idx_o    = w_streaming ? r_cnt : '0;
    assign lane_data_o   = w_streaming ? LANE_W'(w_lane) : '0;
    assign lane_last_o   = w_last;
    assign done_o        = r_done;

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
module tb_keccak_squeeze_serializer;
    import keccak_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  state_valid_i;
    logic                  state_ready_o;
    state_array_t          state_array_i;
    logic [4:0]            num_lanes_i;
    logic                  lane_valid_o;
    logic                  lane_ready_i;
    logic [63:0]           lane_data_o;
    logic [4:0]            lane_idx_o;
    logic                  lane_last_o;
    logic                  done_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keccak_squeeze_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .state_valid_i (state_valid_i),
        .state_ready_o (state_ready_o),
        .state_array_i (state_array_i),
        .num_lanes_i   (num_lanes_i),
        .lane_valid_o  (lane_valid_o),
        .lane_ready_i  (lane_ready_i),
        .lane_data_o   (lane_data_o),
        .lane_idx_o    (lane_idx_o),
        .lane_last_o   (lane_last_o),
        .done_o        (done_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: lane i of the state is A[i mod 5][i div 5].
    function automatic logic [63:0] ref_lane(input state_array_t st, input int i);
        return st[i % 5][i / 5];
    endfunction

    function automatic int ref_n(input int num);
        return (num > 25) ? 25 : num;
    endfunction

    function automatic state_array_t rand_state();
        state_array_t st;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st[x][y] = {$urandom, $urandom};
        return st;
    endfunction

    // Called at a negedge with IDLE outputs; leaves at the negedge after accept.
    task automatic load(input state_array_t st, input int num);
        chk("state_ready_idle", state_ready_o, 1);
        state_valid_i = 1'b1;
        state_array_i = st;
        num_lanes_i   = 5'(num);
        @(negedge clk);
        state_valid_i = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready.
    // stop limits the number of transfers (for abandoning a stream).
    task automatic run_stream(input state_array_t st, input int num, input int mode, input int stop);
        int n;
        int k;
        int cyc;
        int exp_k;
        bit rdy;
        n   = ref_n(num);
        k   = 0;
        cyc = 0;
        while (k < n && k < stop && cyc < 400) begin
            chk("lane_valid", lane_valid_o, 1);
            chk("state_ready_stream", state_ready_o, 0);
            chk("lane_idx", lane_idx_o, k);
            chk("lane_data", lane_data_o, ref_lane(st, k));
            chk("lane_last", lane_last_o, (k == n - 1));
            chk("done_in_stream", done_o, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            lane_ready_i = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        exp_k = (stop < n) ? stop : n;
        chk("stream_transfers", k, exp_k);
        if (stop >= n) begin
            chk("done_pulse", done_o, 1);
            chk("state_ready_after", state_ready_o, 1);
            chk("lane_valid_after", lane_valid_o, 0);
            chk("lane_last_after", lane_last_o, 0);
        end
        lane_ready_i = 1'b0;
        $display("stream num=%0d n=%0d mode=%0d transfers=%0d cycles=%0d", num, n, mode, k, cyc);
    endtask

    initial begin
        state_array_t st_a;
        state_array_t st_b;
        int num;

        rst           = 1'b1;
        state_valid_i = 1'b0;
        state_array_i = '0;
        num_lanes_i   = '0;
        lane_ready_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state_ready", state_ready_o, 1);
        chk("rst_lane_valid", lane_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_lane_idx", lane_idx_o, 0);
        chk("rst_lane_data", lane_data_o, 0);
        chk("rst_lane_last", lane_last_o, 0);
        @(negedge clk);

        // SHA3-256 squeeze with known pattern
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st_a[x][y] = 64'h100 * 64'(x + 5 * y) + 64'hA5;
        load(st_a, 17);
        run_stream(st_a, 17, 0, 99);
        @(negedge clk);
        chk("done_low_sha3", done_o, 0);

        // Backpressure
        st_a = rand_state();
        load(st_a, 4);
        run_stream(st_a, 4, 1, 99);
        @(negedge clk);
        chk("done_low_bp", done_o, 0);

        // Empty load
        st_a = rand_state();
        load(st_a, 0);
        run_stream(st_a, 0, 0, 99);
        @(negedge clk);
        chk("done_low_empty", done_o, 0);
        chk("valid_low_empty", lane_valid_o, 0);

        // Saturation 31 -> 25
        st_a = rand_state();
        load(st_a, 31);
        run_stream(st_a, 31, 0, 99);
        @(negedge clk);
        chk("done_low_sat", done_o, 0);

        // Reset mid-stream
        st_a = rand_state();
        load(st_a, 21);
        run_stream(st_a, 21, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", lane_valid_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_ready", state_ready_o, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_done_after", done_o, 0);
        st_a = rand_state();
        load(st_a, 3);
        run_stream(st_a, 3, 0, 99);
        @(negedge clk);

        // Back-to-back loads with state_valid_i held high
        st_a = rand_state();
        st_b = rand_state();
        chk("b2b_ready", state_ready_o, 1);
        state_valid_i = 1'b1;
        state_array_i = st_a;
        num_lanes_i   = 5'd2;
        @(negedge clk);
        state_array_i = st_b;
        run_stream(st_a, 2, 0, 99);
        @(negedge clk);
        state_valid_i = 1'b0;
        run_stream(st_b, 2, 0, 99);
        @(negedge clk);
        chk("b2b_done_low", done_o, 0);
        chk("b2b_valid_low", lane_valid_o, 0);

        // Randomized loads with random backpressure
        for (int t = 0; t < 8; t++) begin
            st_a = rand_state();
            num  = int'($urandom_range(0, 31));
            load(st_a, num);
            run_stream(st_a, num, 2, 99);
            @(negedge clk);
            chk("done_low_rand", done_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
